proc_io_hub: RTL and testbench
==============================

// Module: proc_io_hub
// PURPOSE
//  Peripheral-side responder for the processor I/O port (req_in/addr_in/io_in, out_en/addr_out/io_out, itr).
//  Buffers one word per input channel from external streaming sources and serves processor reads.
//  Queues processor output writes, tagged with their address, into a FIFO drained by an external sink.
//  Raises itr toward the core when input data arrives. Sits beside the processor top in the SoC wrapper.
// PARAMETERS
//  NUBITS  16  data word width; equals the processor word width
//  NUIOIN   2  number of input channels; must be >=2
//  NUIOOU   2  number of output addresses; must be >=2
//  FDEPTH   4  output FIFO depth; power of 2, >=2
// PORTS
//  clk       in   1                  clock
//  rst       in   1                  synchronous reset, active-high
//  req_in    in   1                  processor read strobe, one cycle per read
//  addr_in   in   $clog2(NUIOIN)     processor read channel
//  io_in     out  NUBITS             read data to the processor
//  out_en    in   1                  processor write strobe
//  addr_out  in   $clog2(NUIOOU)     processor write address
//  io_out    in   NUBITS             write data from the processor
//  itr       out  1                  interrupt pulse to the core
//  src_data  in   NUIOIN*NUBITS      channel i occupies bits [i*NUBITS +: NUBITS]
//  src_vld   in   NUIOIN             per-channel source valid
//  src_rdy   out  NUIOIN             per-channel ready; equals ~hold_vld[i], registered
//  snk_data  out  NUBITS             FIFO head data
//  snk_addr  out  $clog2(NUIOOU)     FIFO head address tag
//  snk_vld   out  1                  FIFO not empty
//  snk_rdy   in   1                  sink accepts the head word
//  ovf       out  1                  sticky flag: a write was dropped
// BEHAVIOUR
//  Reset: all hold_vld=0, io_in=0, itr=0, FIFO empty (snk_vld=0), ovf=0, src_rdy=all 1.
//  Input push: src_vld[i]&src_rdy[i] at an edge -> hold[i]<=src_data[i], hold_vld[i]<=1.
//  Read: req_in at cycle N -> io_in = hold[addr_in] at N+1 if hold_vld is set, else 0.
//    The read clears hold_vld[addr_in] at the same edge. io_in holds its value until the next req_in.
//  Same-cycle read and push on one channel: src_rdy=0 while the word is held, so no push occurs.
//    src_rdy rises the cycle after the pop; no combinational ready path exists.
//  Write: out_en -> {addr_out,io_out} is pushed into the FIFO at that edge.
//    Visible on snk_* one cycle later; the head is registered.
//  FIFO pop: snk_vld&snk_rdy. Push and pop in the same cycle while full: both occur, count unchanged.
//  Push while full with no pop: the word is dropped and ovf<=1. ovf clears only on rst.
//  FIFO pointers wrap modulo FDEPTH. Count width is $clog2(FDEPTH)+1.
//  Output order is strict FIFO across all addresses.
//  An out-of-range addr_in reads 0 and pops nothing.
//  An out-of-range addr_out is still queued with its tag unchanged.
//  rst mid-operation: buffered data is discarded, no partial output is emitted, ovf clears.
// CONFIGURATION
//  PROC_IO_HUB_ITR_EN defined:
//    any_vld = |hold_vld.
//    itr is a one-cycle pulse on a 0->1 transition of any_vld, registered with 1-cycle latency.
//    Further arrivals while any_vld stays 1 produce no new pulse.
//  PROC_IO_HUB_ITR_EN undefined: itr is tied 0 and no interrupt logic is synthesized.
// STRUCTURE
//  Shared package io_hub_pkg holds:
//    localparams for the derived widths INW=$clog2(NUIOIN), OUW=$clog2(NUIOOU), FAW=$clog2(FDEPTH);
//    the FIFO entry packing {addr,data}.
//  Sub-module io_hub_fifo (WIDTH, DEPTH): synchronous FIFO with registered head, full/empty, ovf.
//  Channel holding registers and the read mux live in the top level.
// TESTING
//  1 Reset: assert rst 2 cycles -> src_rdy=2'b11, snk_vld=0, itr=0, ovf=0, io_in=0.
//  2 Input: push 16'h1234 on ch1 -> src_rdy[1]=0; itr pulses once (ITR_EN).
//    Then req_in, addr_in=1 -> io_in=16'h1234 next cycle, src_rdy[1]=1 the cycle after.
//  3 Empty read: req_in, addr_in=0 with no data held -> io_in=0, no state change.
//  4 Output order: writes (0,16'hA), (1,16'hB) with snk_rdy=0 -> head (0,A).
//    Then set snk_rdy=1 -> (0,A) then (1,B) on consecutive cycles, then snk_vld=0.
//  5 Overflow: 5 writes with snk_rdy=0, FDEPTH=4 -> 5th word dropped, ovf=1, FIFO holds the first 4.
//  6 Full boundary: FIFO full, out_en and snk_rdy in the same cycle -> count stays 4, ovf unchanged.
//    Then rst mid-stream -> empty with ovf=0.

Source files
------------

// File: rtl/io_hub_pkg.sv
// Shared definitions for the processor I/O hub: default configuration,
// derived widths and the output FIFO entry layout {addr, data}.
package io_hub_pkg;

  localparam int DEF_NUBITS = 16;
  localparam int DEF_NUIOIN = 2;
  localparam int DEF_NUIOOU = 2;
  localparam int DEF_FDEPTH = 4;

  localparam int INW = $clog2(DEF_NUIOIN);
  localparam int OUW = $clog2(DEF_NUIOOU);
  localparam int FAW = $clog2(DEF_FDEPTH);

  // Output FIFO entry: address tag in the upper bits, data word below.
  typedef struct packed {
    logic [OUW-1:0]        addr;
    logic [DEF_NUBITS-1:0] data;
  } fifo_entry_t;

  // Builds a FIFO entry for the default configuration.
  function automatic fifo_entry_t pack_entry(input logic [OUW-1:0] addr,
                                             input logic [DEF_NUBITS-1:0] data);
    fifo_entry_t e;
    e.addr = addr;
    e.data = data;
    return e;
  endfunction

endpackage

// File: rtl/io_hub_fifo.sv
// Synchronous FIFO with a registered head word, registered not-empty flag and
// a sticky overflow flag. A push while full is accepted only if a pop happens
// in the same cycle; otherwise the word is dropped and ovf sets.
module io_hub_fifo
  import io_hub_pkg::*;
#(
  parameter int WIDTH = OUW + DEF_NUBITS,
  parameter int DEPTH = DEF_FDEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             rdy,
  output logic [WIDTH-1:0] dout,
  output logic             vld,
  output logic             ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] head_r;
  logic             vld_r;
  logic             ovf_r;

  logic             pop_s;
  logic             full_s;
  logic             push_ok_s;
  logic             drop_s;
  logic [AW-1:0]    rd_ptr_nxt_s;
  logic [CW-1:0]    cnt_nxt_s;
  logic [WIDTH-1:0] head_nxt_s;

  // Next-state for pointers, count and the head word seen after this edge.
  always_comb begin
    pop_s        = vld_r & rdy;
    full_s       = (cnt_r == CNT_FULL);
    push_ok_s    = push & (~full_s | pop_s);
    drop_s       = push & full_s & ~pop_s;
    rd_ptr_nxt_s = pop_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
    case ({push_ok_s, pop_s})
      2'b10:   cnt_nxt_s = cnt_r + CNT_ONE;
      2'b01:   cnt_nxt_s = cnt_r - CNT_ONE;
      default: cnt_nxt_s = cnt_r;
    endcase
    // The incoming word becomes the head only when nothing else remains ahead of it.
    if (push_ok_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
      head_nxt_s = din;
    end else begin
      head_nxt_s = mem_r[rd_ptr_nxt_s];
    end
  end

  // Storage, pointers, registered head and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      cnt_r    <= {CW{1'b0}};
      head_r   <= {WIDTH{1'b0}};
      vld_r    <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      rd_ptr_r <= rd_ptr_nxt_s;
      cnt_r    <= cnt_nxt_s;
      head_r   <= head_nxt_s;
      vld_r    <= (cnt_nxt_s != {CW{1'b0}});
      ovf_r    <= ovf_r | drop_s;
    end
  end

  assign dout = head_r;
  assign vld  = vld_r;
  assign ovf  = ovf_r;

endmodule

// File: rtl/proc_io_hub.sv
// Peripheral-side responder for the processor I/O port. Holds one word per
// input channel for processor reads and queues tagged processor writes into
// a FIFO drained by an external sink.
// Optional interrupt generation is enabled by defining PROC_IO_HUB_ITR_EN;
// without it itr is tied low.
module proc_io_hub
  import io_hub_pkg::*;
#(
  parameter int NUBITS = DEF_NUBITS,
  parameter int NUIOIN = DEF_NUIOIN,
  parameter int NUIOOU = DEF_NUIOOU,
  parameter int FDEPTH = DEF_FDEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_in,
  input  logic [$clog2(NUIOIN)-1:0]  addr_in,
  output logic [NUBITS-1:0]          io_in,
  input  logic                       out_en,
  input  logic [$clog2(NUIOOU)-1:0]  addr_out,
  input  logic [NUBITS-1:0]          io_out,
  output logic                       itr,
  input  logic [NUIOIN*NUBITS-1:0]   src_data,
  input  logic [NUIOIN-1:0]          src_vld,
  output logic [NUIOIN-1:0]          src_rdy,
  output logic [NUBITS-1:0]          snk_data,
  output logic [$clog2(NUIOOU)-1:0]  snk_addr,
  output logic                       snk_vld,
  input  logic                       snk_rdy,
  output logic                       ovf
);

  localparam int OU_W = $clog2(NUIOOU);
  localparam int EN_W = OU_W + NUBITS;

  logic [NUBITS-1:0] hold_r [NUIOIN];
  logic [NUIOIN-1:0] hold_vld_r;
  logic [NUIOIN-1:0] src_rdy_r;
  logic [NUBITS-1:0] io_in_r;

  logic [NUIOIN-1:0] push_s;
  logic [NUIOIN-1:0] pop_s;
  logic [NUIOIN-1:0] hold_vld_nxt_s;
  logic [NUBITS-1:0] rd_data_s;

  // Channel push/pop decode and the read mux; an empty or out-of-range read yields 0.
  always_comb begin
    push_s         = {NUIOIN{1'b0}};
    pop_s          = {NUIOIN{1'b0}};
    hold_vld_nxt_s = {NUIOIN{1'b0}};
    rd_data_s      = {NUBITS{1'b0}};
    for (int i = 0; i < NUIOIN; i++) begin
      push_s[i]         = src_vld[i] & src_rdy_r[i];
      pop_s[i]          = req_in & (int'(addr_in) == i) & hold_vld_r[i];
      hold_vld_nxt_s[i] = push_s[i] | (hold_vld_r[i] & ~pop_s[i]);
      rd_data_s         = rd_data_s | (pop_s[i] ? hold_r[i] : {NUBITS{1'b0}});
    end
  end

  // Holding registers, registered ready and the processor read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUIOIN; i++) begin
        hold_r[i] <= {NUBITS{1'b0}};
      end
      hold_vld_r <= {NUIOIN{1'b0}};
      src_rdy_r  <= {NUIOIN{1'b1}};
      io_in_r    <= {NUBITS{1'b0}};
    end else begin
      for (int i = 0; i < NUIOIN; i++) begin
        if (push_s[i]) begin
          hold_r[i] <= src_data[i*NUBITS +: NUBITS];
        end
      end
      hold_vld_r <= hold_vld_nxt_s;
      // Ready drops with the push and returns one cycle after the pop.
      src_rdy_r  <= ~(hold_vld_nxt_s | hold_vld_r);
      if (req_in) begin
        io_in_r <= rd_data_s;
      end
    end
  end

  assign io_in   = io_in_r;
  assign src_rdy = src_rdy_r;

`ifdef PROC_IO_HUB_ITR_EN
  logic any_vld_s;
  logic any_vld_d_r;
  logic itr_r;

  assign any_vld_s = |hold_vld_r;

  // One-cycle interrupt pulse when the first held word appears.
  always_ff @(posedge clk) begin
    if (rst) begin
      any_vld_d_r <= 1'b0;
      itr_r       <= 1'b0;
    end else begin
      any_vld_d_r <= any_vld_s;
      itr_r       <= any_vld_s & ~any_vld_d_r;
    end
  end

  assign itr = itr_r;
`else
  assign itr = 1'b0;
`endif

  logic [EN_W-1:0] fifo_dout_s;

  io_hub_fifo #(
    .WIDTH (EN_W),
    .DEPTH (FDEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (out_en),
    .din  ({addr_out, io_out}),
    .rdy  (snk_rdy),
    .dout (fifo_dout_s),
    .vld  (snk_vld),
    .ovf  (ovf)
  );

  assign snk_addr = fifo_dout_s[EN_W-1 -: OU_W];
  assign snk_data = fifo_dout_s[NUBITS-1:0];

endmodule

// File: tb/tb_proc_io_hub.sv
// Self-checking bench for proc_io_hub: directed scenarios followed by random
// traffic. A queue-based reference model predicts read data, channel ready,
// sink stream contents, overflow and interrupt; a negedge monitor compares.
module tb_proc_io_hub;
  import io_hub_pkg::*;

  localparam int NB = DEF_NUBITS;
  localparam int NI = DEF_NUIOIN;
  localparam int FD = DEF_FDEPTH;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               req_in = 1'b0;
  logic [INW-1:0]     addr_in = '0;
  logic [NB-1:0]      io_in;
  logic               out_en = 1'b0;
  logic [OUW-1:0]     addr_out = '0;
  logic [NB-1:0]      io_out = '0;
  logic               itr;
  logic [NI*NB-1:0]   src_data = '0;
  logic [NI-1:0]      src_vld = '0;
  logic [NI-1:0]      src_rdy;
  logic [NB-1:0]      snk_data;
  logic [OUW-1:0]     snk_addr;
  logic               snk_vld;
  logic               snk_rdy = 1'b0;
  logic               ovf;

  proc_io_hub dut (
    .clk(clk), .rst(rst), .req_in(req_in), .addr_in(addr_in), .io_in(io_in),
    .out_en(out_en), .addr_out(addr_out), .io_out(io_out), .itr(itr),
    .src_data(src_data), .src_vld(src_vld), .src_rdy(src_rdy),
    .snk_data(snk_data), .snk_addr(snk_addr), .snk_vld(snk_vld),
    .snk_rdy(snk_rdy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  // Reference model state
  logic [NB-1:0]  m_hold [NI];
  bit             m_vld [NI];
  bit             m_popped [NI];
  int             m_cnt = 0;
  bit             m_ovf = 1'b0;
  bit             any_p1 = 1'b0;
  bit             any_p2 = 1'b0;
  fifo_entry_t    exp_q [$];
  logic [NB-1:0]  rd_q [$];
  logic [NB-1:0]  cur_io = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs applied for that edge.
  task automatic model_edge();
    bit rdy [NI];
    bit new_pop [NI];
    bit any_now;
    bit pop;
    int a;
    if (rst) begin
      for (int i = 0; i < NI; i++) begin
        m_vld[i] = 1'b0;
        m_popped[i] = 1'b0;
      end
      m_cnt = 0;
      m_ovf = 1'b0;
      any_p1 = 1'b0;
      any_p2 = 1'b0;
      exp_q.delete();
      rd_q.delete();
      rd_q.push_back('0);
    end else begin
      any_now = 1'b0;
      for (int i = 0; i < NI; i++) begin
        rdy[i] = !m_vld[i] && !m_popped[i];
        new_pop[i] = 1'b0;
        any_now = any_now | m_vld[i];
      end
      any_p2 = any_p1;
      any_p1 = any_now;
      if (req_in) begin
        a = int'(addr_in);
        if (a < NI && m_vld[a]) begin
          rd_q.push_back(m_hold[a]);
          m_vld[a] = 1'b0;
          new_pop[a] = 1'b1;
        end else begin
          rd_q.push_back('0);
        end
      end
      for (int i = 0; i < NI; i++) begin
        if (src_vld[i] && rdy[i]) begin
          m_hold[i] = src_data[i*NB +: NB];
          m_vld[i] = 1'b1;
        end
        m_popped[i] = new_pop[i];
      end
      pop = (m_cnt > 0) && snk_rdy;
      if (out_en) begin
        if (m_cnt < FD || pop) begin
          exp_q.push_back(pack_entry(addr_out, io_out));
          m_cnt++;
        end else begin
          m_ovf = 1'b1;
        end
      end
      if (pop) m_cnt--;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Monitor: compare DUT outputs against the model away from the active edge.
  always @(negedge clk) begin
    logic [NI-1:0] exp_rdy;
    bit exp_itr;
    if (mon_en) begin
      if (rd_q.size() > 0) cur_io = rd_q.pop_front();
      chk("io_in", 32'(io_in), 32'(cur_io));
      for (int i = 0; i < NI; i++) exp_rdy[i] = !m_vld[i] && !m_popped[i];
      chk("src_rdy", 32'(src_rdy), 32'(exp_rdy));
      chk("snk_vld", 32'(snk_vld), 32'(m_cnt > 0));
      chk("ovf", 32'(ovf), 32'(m_ovf));
`ifdef PROC_IO_HUB_ITR_EN
      exp_itr = any_p1 && !any_p2;
`else
      exp_itr = 1'b0;
`endif
      chk("itr", 32'(itr), 32'(exp_itr));
      if (snk_vld === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL sink_unexpected: got addr %0h data %0h expected no word at %0t",
                   snk_addr, snk_data, $time);
        end else begin
          chk("snk_addr", 32'(snk_addr), 32'(exp_q[0].addr));
          chk("snk_data", 32'(snk_data), 32'(exp_q[0].data));
          if (snk_rdy) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    // 1: reset for two cycles
    rst = 1'b1;
    tick();
    mon_en = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // 2: push on channel 1, then read it back
    src_data = {16'h1234, 16'h0000};
    src_vld = 2'b10;
    tick();
    src_vld = 2'b00;
    tick();
    tick();
    req_in = 1'b1; addr_in = 1'b1;
    tick();
    req_in = 1'b0;
    tick();
    tick();

    // 3: read of an empty channel
    req_in = 1'b1; addr_in = 1'b0;
    tick();
    req_in = 1'b0;
    tick();

    // 4: ordered output across addresses
    snk_rdy = 1'b0;
    out_en = 1'b1; addr_out = 1'b0; io_out = 16'h000A;
    tick();
    addr_out = 1'b1; io_out = 16'h000B;
    tick();
    out_en = 1'b0;
    tick();
    snk_rdy = 1'b1;
    tick(); tick(); tick();
    snk_rdy = 1'b0;

    // 5: overflow on the fifth write
    for (int k = 0; k < 5; k++) begin
      out_en = 1'b1; addr_out = OUW'(k); io_out = 16'h0100 + NB'(k);
      tick();
    end
    out_en = 1'b0;
    tick();

    // 6: full with simultaneous write and drain, then reset mid-stream
    out_en = 1'b1; snk_rdy = 1'b1; addr_out = 1'b1; io_out = 16'h0BEE;
    tick();
    out_en = 1'b0; snk_rdy = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // Random traffic
    for (int c = 0; c < 2000; c++) begin
      rst      = ($urandom_range(0, 299) == 0);
      src_data = {$urandom, $urandom};
      src_vld  = NI'($urandom);
      req_in   = ($urandom_range(0, 2) == 0);
      addr_in  = INW'($urandom);
      out_en   = ($urandom_range(0, 1) == 1);
      addr_out = OUW'($urandom);
      io_out   = NB'($urandom);
      snk_rdy  = ($urandom_range(0, 1) == 1);
      tick();
    end

    // Drain
    rst = 1'b0; src_vld = '0; req_in = 1'b0; out_en = 1'b0; snk_rdy = 1'b1;
    for (int c = 0; c < 8; c++) tick();
    chk("drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
